face_scan_writer: RTL and testbench
===================================

# face_scan_writer

Sequencer that fills one 3x3 face store from a stream of colour-sensor samples. It averages 2^N_AVG_LOG2 consecutive samples per sticker and writes the result into the face RAM in raster order: row `addr1` 0..2, column `addr2` 0..2. It sits directly upstream of the 3x3 face RAM and drives that RAM's `we`/`data`/`addr1`/`addr2` ports. It pulses `face_done` once all nine stickers are written.

## Interface

Parameters:
- `S_DATA`, 16: sample and stored-word width.
- `N_AVG_LOG2`, 2: log2 of the number of samples averaged per sticker (1..4).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `clear`  in  1  reset; asynchronous, active-low (0 = reset).
- `start`  in  1  begin a face scan; sampled only in IDLE.
- `sample_valid`  in  1  `sample_data` is valid this cycle.
- `sample_data`  in  S_DATA  colour sample, unsigned.
- `sample_ready`  out  1  block accepts a sample this cycle.
- `we`  out  1  RAM write enable.
- `data`  out  S_DATA  averaged sticker value to the RAM.
- `addr1`  out  2  RAM row.
- `addr2`  out  2  RAM column.
- `busy`  out  1  high in every state except IDLE.
- `face_done`  out  1  one-cycle pulse after the ninth write.

## Operation

- FSM states: IDLE, ACCUM, SETUP, WRITE, DONE.
- IDLE: all outputs 0. If `start`=1, go to ACCUM with accumulator, sample count, row and column all cleared to 0.
- ACCUM:
  - `sample_ready`=1. A sample is accepted when `sample_valid`&&`sample_ready`.
  - Each accepted sample is added to an accumulator of width S_DATA+N_AVG_LOG2; no overflow is possible.
  - On acceptance of sample number 2^N_AVG_LOG2, register `data` = (acc + sample_data) >> N_AVG_LOG2 (truncating). Then clear acc and count, and go to SETUP.
  - `sample_valid`=0 stalls indefinitely with no state change.
- SETUP: `we`=0 and `sample_ready`=0; `addr1`/`addr2`/`data` hold the current sticker. This cycle lets the RAM register the address before the write. Next state is WRITE.
- WRITE: `we`=1 for exactly one cycle; addr and data unchanged from SETUP.
  - If (row,col)=(2,2), go to DONE.
  - Otherwise col++ (col 2 wraps to 0 with row++) and go to ACCUM.
- DONE: `face_done`=1 for one cycle, then IDLE. Row/col return to 0. `data` holds its last value until the next start.
- Address values 3 are never driven.
- `start` is ignored while `busy`=1.
- `sample_valid` is ignored outside ACCUM; samples arriving while `sample_ready`=0 are not accepted and not counted.

## Timing

- Reset (`clear`=0, any state, any time): immediately IDLE. `we`, `data`, `addr1`, `addr2`, `sample_ready`, `busy` and `face_done` all 0; accumulator, count, row and col all 0. Any partial face is abandoned; RAM contents already written are not touched.
- Reset release: first active edge sees IDLE.
- Start latency: `start` sampled at edge k puts the block in ACCUM from cycle k+1, with `sample_ready`=1 in that cycle.
- Per-sticker minimum: 2^N_AVG_LOG2 ACCUM cycles + 1 SETUP + 1 WRITE (6 cycles at default).
- Full face with continuous `sample_valid`: 9 × 6 = 54 cycles at default. The last WRITE is in cycle k+54 and `face_done` is high in cycle k+55.
- Earliest restart: `busy` falls in cycle k+56; a new `start` can be accepted from that cycle.
- `we` is never high in two consecutive cycles. Every `we` pulse is preceded by a cycle with `we`=0 and identical addr/data.

## Test plan

- Basic average: `start`, then samples 100,101,102,103 → SETUP at addr (0,0) with `data`=101; `we` pulses once in the next cycle; `sample_ready` reasserts one cycle after WRITE.
- Full face, continuous valid, sticker i fed four copies of value 16·i → nine `we` pulses at addr (0,0),(0,1),(0,2),(1,0)…(2,2) with `data` 0,16,…,128; `face_done` high exactly at cycle k+55.
- Saturation/width: four samples of 0xFFFF → `data`=0xFFFF. Samples 0,0,0,3 → `data`=0 (truncation).
- Stalls: `sample_valid` toggled randomly and asserted during SETUP/WRITE/IDLE → only ACCUM handshakes are counted; written values match the software average.
- Reset mid-operation: `clear`=0 during the fifth sticker's ACCUM → all outputs 0 immediately. After release, a new `start` writes from (0,0) again with a fresh accumulator.
- `start` held high throughout a scan → no restart; `face_done` pulses once; a new scan begins from the IDLE cycle after DONE.

Source files
------------

// File: rtl/face_scan_writer.sv
`default_nettype none
// ============================================================================
// face_scan_writer : averages colour samples per sticker, writes a 3x3 face RAM
// Revision 1.0
// ============================================================================
module face_scan_writer #(
  parameter int S_DATA     = 16,
  parameter int N_AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [S_DATA-1:0] sample_data,
  output logic              sample_ready,
  output logic              we,
  output logic [S_DATA-1:0] data,
  output logic [1:0]        addr1,
  output logic [1:0]        addr2,
  output logic              busy,
  output logic              face_done
);

  localparam int ACC_W = S_DATA + N_AVG_LOG2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACCUM = 3'd1;
  localparam logic [2:0] SETUP = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [N_AVG_LOG2-1:0] CNT_LAST = '1;

  logic [2:0]            state;
  logic [2:0]            state_next;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      sum;
  logic [N_AVG_LOG2-1:0] cnt;
  logic [1:0]            row;
  logic [1:0]            col;
  logic [S_DATA-1:0]     data_q;
  logic                  accept;
  logic                  last_sample;
  logic                  last_sticker;

  assign accept       = (state == ACCUM) && sample_valid;
  assign last_sample  = accept && (cnt == CNT_LAST);
  assign last_sticker = (row == 2'd2) && (col == 2'd2);
  assign sum          = acc + ACC_W'(sample_data);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (last_sample) state_next = SETUP;
      SETUP:   state_next = WRITE;
      WRITE:   state_next = last_sticker ? DONE : ACCUM;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sample_ready = (state == ACCUM);
    we           = (state == WRITE);
    busy         = (state != IDLE);
    face_done    = (state == DONE);
    addr1        = row;
    addr2        = col;
    data         = data_q;
  end

  // Sticker position advances on the WRITE cycle so SETUP/WRITE see a stable address.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      acc    <= '0;
      cnt    <= '0;
      row    <= 2'd0;
      col    <= 2'd0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            cnt <= '0;
            row <= 2'd0;
            col <= 2'd0;
          end
        end
        ACCUM: begin
          if (last_sample) begin
            data_q <= S_DATA'(sum >> N_AVG_LOG2);
            acc    <= '0;
            cnt    <= '0;
          end else if (accept) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: begin
          if (last_sticker) begin
            row <= 2'd0;
            col <= 2'd0;
          end else if (col == 2'd2) begin
            col <= 2'd0;
            row <= row + 2'd1;
          end else begin
            col <= col + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_face_scan_writer.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for face_scan_writer: directed vector table plus randomized scans
// checked against a sticker-average model.
module tb_face_scan_writer;

  logic        clk;
  logic        clear;
  logic        start;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;
  logic        we;
  logic [15:0] data;
  logic [1:0]  addr1;
  logic [1:0]  addr2;
  logic        busy;
  logic        face_done;

  face_scan_writer #(.S_DATA(16), .N_AVG_LOG2(2)) dut (
    .clk(clk), .clear(clear), .start(start),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(sample_ready), .we(we), .data(data),
    .addr1(addr1), .addr2(addr2), .busy(busy), .face_done(face_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  a1;
    logic [1:0]  a2;
    logic [15:0] d;
    int          c;
  } wr_t;

  typedef struct {
    logic [15:0] s0, s1, s2, s3;
    logic [15:0] exp;
  } vec_t;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  wr_t         wr_q[$];
  int          done_q[$];
  logic [15:0] samp[36];
  vec_t        tbl[6];

  logic        prev_we;
  logic [1:0]  prev_a1, prev_a2;
  logic [15:0] prev_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Observes every WRITE, its preceding SETUP cycle, and face_done pulses.
  always @(posedge clk) begin
    #1;
    if (we === 1'b1) begin
      chk("we_prev_low", {31'd0, prev_we}, 32'd0);
      chk("setup_addr", {28'd0, prev_a1, prev_a2}, {28'd0, addr1, addr2});
      chk("setup_data", {16'd0, prev_d}, {16'd0, data});
      chk("ready_in_write", {31'd0, sample_ready}, 32'd0);
      wr_q.push_back('{a1: addr1, a2: addr2, d: data, c: cyc});
    end
    if (face_done === 1'b1) done_q.push_back(cyc);
    prev_we = we;
    prev_a1 = addr1;
    prev_a2 = addr2;
    prev_d  = data;
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, sample_ready}, 32'd0);
    chk({tag, "_we"},    {31'd0, we},           32'd0);
    chk({tag, "_data"},  {16'd0, data},         32'd0);
    chk({tag, "_addr"},  {28'd0, addr1, addr2}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy},         32'd0);
    chk({tag, "_done"},  {31'd0, face_done},    32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    clear = 1'b0; start = 1'b0; sample_valid = 1'b0;
    #1;
    check_zero_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
  endtask

  task automatic drive_sample(input int idx, input logic rdy, input int pct);
    sample_valid = ($urandom_range(99) < pct);
    sample_data  = rdy ? samp[idx] : 16'($urandom);
  endtask

  // Feeds samp[0..abort_at-1] honouring the handshake, then checks the face.
  task automatic run_scan(input int pct, input bit hold, input bit timing, input int abort_at);
    int idx, guard, ks, n;
    logic rdy_seen;
    bit first;
    logic [17:0] sum;
    idx = 0; guard = 0; first = 1'b1;
    wr_q.delete();
    done_q.delete();
    @(negedge clk);
    start = 1'b1;
    ks = cyc + 1;
    rdy_seen = sample_ready;
    drive_sample(idx, rdy_seen, pct);
    while (idx < abort_at && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (!hold) start = 1'b0;
      if (sample_valid && rdy_seen) idx++;
      if (first && timing) begin
        chk("start_latency_ready", {31'd0, sample_ready}, 32'd1);
        chk("start_latency_busy",  {31'd0, busy},         32'd1);
      end
      first = 1'b0;
      rdy_seen = sample_ready;
      if (idx < abort_at) drive_sample(idx, rdy_seen, pct);
      else sample_valid = 1'b0;
    end
    if (guard >= 4000) chk("feed_timeout", 32'd1, 32'd0);
    if (abort_at < 36) return;
    guard = 0;
    while (done_q.size() == 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("face_done_seen", {31'd0, done_q.size() > 0}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, face_done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    if (hold) begin
      chk("restart_busy",  {31'd0, busy},         32'd1);
      chk("restart_ready", {31'd0, sample_ready}, 32'd1);
      start = 1'b0;
    end
    chk("done_pulse_count", done_q.size(), 32'd1);
    chk("write_count", wr_q.size(), 32'd9);
    for (int i = 0; i < 9 && i < wr_q.size(); i++) begin
      sum = 18'd0;
      for (int j = 0; j < 4; j++) sum += 18'(samp[4*i+j]);
      n = i;
      chk("wr_row",  {30'd0, wr_q[i].a1}, n / 3);
      chk("wr_col",  {30'd0, wr_q[i].a2}, n % 3);
      chk("wr_data", {16'd0, wr_q[i].d},  {16'd0, 16'(sum / 4)});
      if (timing) chk("wr_cycle", wr_q[i].c, ks + 5 + 6 * i);
    end
    if (timing && done_q.size() > 0) chk("done_cycle", done_q[0], ks + 54);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'd100,    16'd101,    16'd102,    16'd103,    16'd101};
    tbl[1] = '{16'hFFFF,   16'hFFFF,   16'hFFFF,   16'hFFFF,   16'hFFFF};
    tbl[2] = '{16'd0,      16'd0,      16'd0,      16'd3,      16'd0};
    tbl[3] = '{16'd1,      16'd2,      16'd3,      16'd4,      16'd2};
    tbl[4] = '{16'd7,      16'd7,      16'd7,      16'd6,      16'd6};
    tbl[5] = '{16'h8000,   16'h8000,   16'h8000,   16'h7FFF,   16'h7FFF};

    clear = 1'b0; start = 1'b0; sample_valid = 1'b0; sample_data = 16'd0;
    prev_we = 1'b0; prev_a1 = 2'd0; prev_a2 = 2'd0; prev_d = 16'd0;
    #2;
    check_zero_outputs("por");

    foreach (tbl[r]) begin
      do_reset("rst_vec");
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("vec_ready_accum", {31'd0, sample_ready}, 32'd1);
      sample_valid = 1'b1; sample_data = tbl[r].s0;
      @(negedge clk); sample_data = tbl[r].s1;
      @(negedge clk); sample_data = tbl[r].s2;
      @(negedge clk); sample_data = tbl[r].s3;
      @(negedge clk); sample_data = 16'($urandom);
      chk("vec_setup_ready", {31'd0, sample_ready}, 32'd0);
      chk("vec_setup_we",    {31'd0, we},           32'd0);
      chk("vec_setup_addr",  {28'd0, addr1, addr2}, 32'd0);
      chk("vec_setup_data",  {16'd0, data},         {16'd0, tbl[r].exp});
      @(negedge clk);
      chk("vec_write_we",    {31'd0, we},           32'd1);
      chk("vec_write_data",  {16'd0, data},         {16'd0, tbl[r].exp});
      @(negedge clk);
      sample_valid = 1'b0;
      chk("vec_ready_again", {31'd0, sample_ready}, 32'd1);
      chk("vec_we_dropped",  {31'd0, we},           32'd0);
    end

    do_reset("rst_full");
    for (int i = 0; i < 36; i++) samp[i] = 16'(16 * (i / 4));
    run_scan(100, 1'b0, 1'b1, 36);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 36; i++) samp[i] = 16'($urandom);
      run_scan(60, 1'b0, 1'b0, 36);
    end
    for (int i = 0; i < 36; i++) samp[i] = ($urandom_range(1) == 1) ? 16'hFFFF : 16'h0000;
    run_scan(80, 1'b0, 1'b0, 36);

    for (int i = 0; i < 36; i++) samp[i] = 16'($urandom);
    run_scan(70, 1'b0, 1'b0, 18);
    @(negedge clk);
    #2;
    clear = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk);
    clear = 1'b1;
    for (int i = 0; i < 36; i++) samp[i] = 16'($urandom);
    run_scan(70, 1'b0, 1'b0, 36);

    for (int i = 0; i < 36; i++) samp[i] = 16'($urandom);
    run_scan(100, 1'b1, 1'b1, 36);

    do_reset("rst_end");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
